hps_cmd_decoder: RTL

Downstream consumer of the HPS SPI word interface. It takes each 16-bit word and strobe produced by the SPI deserialiser, frames words into commands while `io_enable` is high, and decodes a fixed command set into core-side registers (joystick, status, keyboard). It also drives the response word that the deserialiser shifts back to the HPS on the next transfer.

---
 rtl/hps_pkg.sv | 26 ++
 rtl/hps_sync2.sv | 22 ++
 rtl/hps_cmd_decoder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hps_pkg.sv
// Shared constants for the HPS command decoder: opcodes, FSM states and
// the data-word counter width.
package hps_pkg;

  // Data-word index counter width; the counter saturates at its maximum.
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Command opcodes carried in bits [7:0] of the first word of a frame.
  localparam logic [7:0] CMD_CORE_ID    = 8'h00;
  localparam logic [7:0] CMD_JOY0       = 8'h02;
  localparam logic [7:0] CMD_KBD        = 8'h05;
  localparam logic [7:0] CMD_STATUS_SET = 8'h1E;
  localparam logic [7:0] CMD_STATUS_GET = 8'h29;

  // Number of 16-bit words making up the 64-bit status register.
  localparam int STATUS_WORDS = 4;

  // Frame-level FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/hps_sync2.sv
// Two-flop level synchroniser for a signal arriving asynchronously to clk.
module hps_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous level to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hps_cmd_decoder.sv
// Frames SPI words into commands while io_enable is high and decodes them
// into core-side registers. Also produces the word returned to the HPS on
// the following transfer.
module hps_cmd_decoder
  import hps_pkg::*;
#(
  parameter logic [15:0] CORE_ID = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic [15:0] io_word,
  input  logic        io_strobe,
  input  logic        io_enable,
  output logic [15:0] resp_word,
  output logic [31:0] joystick_0,
  output logic [63:0] status,
  output logic        status_upd,
  output logic [7:0]  kbd_code,
  output logic        kbd_valid
);

  logic             en_s;
  state_t           state;
  logic [7:0]       cmd;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      shadow;
  logic [63:0]      status_next;

  hps_sync2 u_en_sync (
    .clk   (sys_clk),
    .rst_n (reset_n),
    .d     (io_enable),
    .q     (en_s)
  );

  // Response word the HPS reads back for a given opcode and response index.
  // The index is one bit wider than cnt so "after the last word" is distinct.
  function automatic logic [15:0] resp_sel(input logic [7:0]     op,
                                           input logic [CNT_W:0] idx,
                                           input logic [63:0]    st);
    logic [15:0] r;
    r = '0;
    case (op)
      CMD_CORE_ID:    if (idx == '0) r = CORE_ID;
      CMD_STATUS_GET: if (idx[CNT_W:2] == '0) r = st[{idx[1:0], 4'b0000} +: 16];
      default:        r = '0;
    endcase
    return r;
  endfunction

  // Candidate status value completed by the final status word of a frame.
  assign status_next = {io_word, shadow[47:0]};

  // Frame FSM, command decode and all registered outputs.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmd        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      resp_word  <= '0;
      joystick_0 <= '0;
      status     <= '0;
      status_upd <= 1'b0;
      kbd_code   <= '0;
      kbd_valid  <= 1'b0;
    end else begin
      status_upd <= 1'b0;
      kbd_valid  <= 1'b0;

      if (!en_s) begin
        // Framing dropped: abandon any command; a coincident strobe is lost.
        state     <= IDLE;
        cmd       <= '0;
        cnt       <= '0;
        resp_word <= '0;
      end else begin
        case (state)
          IDLE: begin
            // First enabled cycle only arms the FSM; strobes here are ignored.
            state     <= CMD;
            resp_word <= '0;
          end

          CMD: begin
            if (io_strobe) begin
              cmd       <= io_word[7:0];
              cnt       <= '0;
              state     <= DATA;
              resp_word <= resp_sel(io_word[7:0], '0, status);
            end
          end

          DATA: begin
            if (io_strobe) begin
              cnt       <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
              resp_word <= resp_sel(cmd, {1'b0, cnt} + 1'b1, status);

              case (cmd)
                CMD_JOY0: begin
                  if (cnt == CNT_W'(0))      joystick_0[15:0]  <= io_word;
                  else if (cnt == CNT_W'(1)) joystick_0[31:16] <= io_word;
                end

                CMD_KBD: begin
                  if (cnt == CNT_W'(0)) begin
                    kbd_code  <= io_word[7:0];
                    kbd_valid <= 1'b1;
                  end
                end

                CMD_STATUS_SET: begin
                  // Shadow collects LSW first; status commits atomically on
                  // the last word so a truncated frame never tears it.
                  if (cnt == CNT_W'(0))      shadow[15:0]  <= io_word;
                  else if (cnt == CNT_W'(1)) shadow[31:16] <= io_word;
                  else if (cnt == CNT_W'(2)) shadow[47:32] <= io_word;
                  else if (cnt == CNT_W'(STATUS_WORDS - 1)) begin
                    shadow[63:48] <= io_word;
                    status        <= status_next;
                    status_upd    <= (status_next != status);
                  end
                end

                default: ;
              endcase
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
